sdmac_reg_ctrl: RTL and testbench
=================================

Name: sdmac_reg_ctrl

Overview:
- Register-access front end of the ReSDMAC SCSI DMA controller.
- Decodes CPU cycles to the SDMAC chip select into per-register read/write/action strobes.
- Holds the 9-bit control register (DMA enable, direction, interrupt enable, peripheral reset) and the flash-address register.
- Runs a flash-access engine that bridges FLASH_DATA register cycles onto an Avalon-MM on-chip-flash port and produces a cycle-termination flag.

Parameters:
FLASH_AW, 19, flash word-address width driven on avm_addr.
CNTR_RST, 9'h000, control register reset value.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RST_  in  1  asynchronous active-low reset.
ADDR  in  8  CPU byte address A7..A0.
DMAC_  in  1  active-low SDMAC chip select.
AS_  in  1  active-low CPU address strobe.
RW  in  1  1=read, 0=write.
MID  in  32  CPU write data.
WDREGREQ  out  1  WD33C93 register access request.
h_0C, h_28  out  1  any-access hits at 0x0C / 0x28.
WTC_RD_, CONTR_RD_, ISTR_RD_, SSPBDAT_RD_, VERSION_RD_, DEV_RD_, DSP_RD_, FLASH_ADDR_RD_, FLASH_DATA_RD_  out  1 each  active-low read selects.
CONTR_WR, ACR_WR, SSPBDAT_WR, VERSION_WR, FLASH_ADDR_WR, FLASH_DATA_WR  out  1 each  active-high write strobes.
ST_DMA, SP_DMA, CLR_INT  out  1  active-high action strobes.
FLUSH_  out  1  active-low flush strobe.
CNTR_O  out  9  control register readback.
INTENA, PRESET, DMADIR, DMAENA  out  1  control outputs.
FLASH_ADDR  out  24  flash address register.
FLASH_DATA_OUT  out  32  last word read from flash.
FLASH_TERM  out  1  flash cycle complete.
avm_addr  out  FLASH_AW  flash word address.
avm_read, avm_write  out  1  Avalon-MM read / write request.
avm_wdata  out  32  Avalon-MM write data.
avm_rdata  in  32  Avalon-MM read data.
avm_waitrequest, avm_readdatavalid  in  1  Avalon-MM handshake.

Behaviour:
- Decode: combinational. Qualifier is sel = ~DMAC_ & ~AS_. Longword decode on ADDR[7:2]; ADDR[1:0] are ignored except in the WD window.
- Register map:
  - 0x04 WTC (read only)
  - 0x08 CNTR (read/write)
  - 0x0C ACR (write only; h_0C asserts on any access)
  - 0x10 ST_DMA, 0x14 FLUSH_, 0x18 CLR_INT, 0x3C SP_DMA: actions on read or write
  - 0x1C ISTR (read)
  - 0x28 h_28 (any access)
  - 0x40–0x4F WDREGREQ (any access)
  - 0x58 SSPBDAT (read/write)
  - 0x60 VERSION (read/write)
  - 0x64 DEV (read)
  - 0x68 DSP (read)
  - 0x6C FLASH_ADDR (read/write)
  - 0x70 FLASH_DATA (read/write)
- *_RD_ requires RW=1; *_WR requires RW=0. Writes to read-only addresses and reads of write-only addresses produce no strobe. Unmapped addresses produce no strobe.
- At most one read select, one write strobe, or one action strobe is active at a time.
- CNTR:
  - Reset value CNTR_RST.
  - CONTR_WR loads MID[8:0] each clock it is high.
  - CNTR_O = register value.
  - INTENA = bit2. PRESET = bit4. DMADIR = ~bit1, so reset DMADIR = 1.
- DMAENA:
  - Resets to 0. ST_DMA sets it; SP_DMA clears it.
  - If ST_DMA and SP_DMA are both high, SP_DMA wins.
  - CONTR_WR does not affect DMAENA.
- FLASH_ADDR: resets to 0; loads MID[23:0] on FLASH_ADDR_WR.
- Flash FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, TERM. Reset state is IDLE with all Avalon outputs 0, FLASH_TERM=0, FLASH_DATA_OUT=0.
  - IDLE → RD_REQ when FLASH_DATA_RD_=0. IDLE → WR_REQ when FLASH_DATA_WR=1; avm_wdata captures MID on entry.
  - RD_REQ: avm_read=1, avm_addr=FLASH_ADDR[FLASH_AW-1:0]. Held until avm_waitrequest=0, then → RD_WAIT.
  - RD_WAIT: on avm_readdatavalid, FLASH_DATA_OUT ← avm_rdata, → TERM.
  - WR_REQ: avm_write=1 until avm_waitrequest=0, then → TERM.
  - TERM: FLASH_TERM=1 until the cycle ends (both FLASH_DATA_RD_=1 and FLASH_DATA_WR=0), then → IDLE. A new flash cycle therefore needs AS_ deasserted first.
  - If the CPU strobe drops in RD_REQ/WR_REQ, the Avalon request is still completed; TERM is then entered and released the next cycle.
  - Reset mid-transaction returns to IDLE immediately. FLASH_DATA_OUT is cleared.

Optional Feature:
- FLASH_EN defined: flash FSM and Avalon port as above.
- FLASH_EN undefined: FSM removed. Avalon outputs tied 0. FLASH_DATA_OUT=0. FLASH_TERM=0. Decode of 0x6C/0x70 and the FLASH_ADDR register remain.

Decomposition:
- Package sdmac_reg_pkg holds:
  - address-offset localparams
  - CNTR bit-index constants (PRESET=4, INTEN=2, DDIR=1)
  - flash FSM state enum
- One sub-module: sdmac_flash_if (FSM plus Avalon port); decode and CNTR stay in the top.

Test Plan:
- Reset: RST_=0 → CNTR_O=0, DMAENA=0, DMADIR=1, INTENA=0, PRESET=0, FLASH_TERM=0, all strobes inactive.
- Write 0x08, MID=0x016 → after 1 clock CNTR_O=0x016, INTENA=1, PRESET=1, DMADIR=0; read 0x08 asserts only CONTR_RD_.
- Access 0x10 → DMAENA=1; access 0x3C → DMAENA=0; ST_DMA/SP_DMA forced high together → DMAENA=0.
- Sweep all 64 longword addresses with RW=0/1, DMAC_=1 → no strobes; DMAC_=0 → exactly the mapped strobe. ADDR=0x43 → WDREGREQ=1. Write 0x0C → ACR_WR=1 and h_0C=1.
- Write 0x6C MID=0x000123, then read 0x70; model waitrequest for 2 cycles and readdatavalid 3 cycles later with 0xDEADBEEF → avm_addr=0x123, FLASH_DATA_OUT=0xDEADBEEF, FLASH_TERM high until AS_=1.
- Write 0x70 MID=0xCAFEF00D → avm_write=1 with avm_wdata=0xCAFEF00D, then FLASH_TERM=1; assert reset during RD_WAIT → FSM IDLE, FLASH_TERM=0.

Source files
------------

// File: rtl/sdmac_reg_pkg.sv
// Shared constants for the SDMAC register front end: register offsets,
// control-register bit positions and the flash-engine state encoding.
package sdmac_reg_pkg;

    localparam logic [7:0] OFS_WTC        = 8'h04;
    localparam logic [7:0] OFS_CNTR       = 8'h08;
    localparam logic [7:0] OFS_ACR        = 8'h0C;
    localparam logic [7:0] OFS_ST_DMA     = 8'h10;
    localparam logic [7:0] OFS_FLUSH      = 8'h14;
    localparam logic [7:0] OFS_CLR_INT    = 8'h18;
    localparam logic [7:0] OFS_ISTR       = 8'h1C;
    localparam logic [7:0] OFS_H28        = 8'h28;
    localparam logic [7:0] OFS_SP_DMA     = 8'h3C;
    localparam logic [7:0] OFS_WD_BASE    = 8'h40;
    localparam logic [7:0] OFS_SSPBDAT    = 8'h58;
    localparam logic [7:0] OFS_VERSION    = 8'h60;
    localparam logic [7:0] OFS_DEV        = 8'h64;
    localparam logic [7:0] OFS_DSP        = 8'h68;
    localparam logic [7:0] OFS_FLASH_ADDR = 8'h6C;
    localparam logic [7:0] OFS_FLASH_DATA = 8'h70;

    localparam int CNTR_PRESET = 4;
    localparam int CNTR_INTEN  = 2;
    localparam int CNTR_DDIR   = 1;

    typedef enum logic [2:0] {
        FL_IDLE    = 3'd0,
        FL_RD_REQ  = 3'd1,
        FL_RD_WAIT = 3'd2,
        FL_WR_REQ  = 3'd3,
        FL_TERM    = 3'd4
    } flash_state_e;

endpackage

// File: rtl/sdmac_flash_if.sv
// Flash-access engine: turns FLASH_DATA register cycles into Avalon-MM
// reads/writes and holds FLASH_TERM until the CPU cycle ends.
module sdmac_flash_if
    import sdmac_reg_pkg::*;
#(
    parameter int FLASH_AW = 19
) (
    input  logic                CLK,
    input  logic                RST_,
    input  logic                FLASH_DATA_RD_,
    input  logic                FLASH_DATA_WR,
    input  logic [FLASH_AW-1:0] flash_addr,
    input  logic [31:0]         MID,
    output logic [FLASH_AW-1:0] avm_addr,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_wdata,
    input  logic [31:0]         avm_rdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid,
    output logic [31:0]         FLASH_DATA_OUT,
    output logic                FLASH_TERM
);

    flash_state_e       state_r;
    flash_state_e       state_nx_s;
    logic [FLASH_AW-1:0] addr_r;
    logic [31:0]         wdata_r;
    logic [31:0]         dout_r;

    // State register
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_r <= FL_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; an accepted Avalon request always runs to TERM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            FL_IDLE: begin
                if (!FLASH_DATA_RD_) begin
                    state_nx_s = FL_RD_REQ;
                end else if (FLASH_DATA_WR) begin
                    state_nx_s = FL_WR_REQ;
                end else begin
                    state_nx_s = FL_IDLE;
                end
            end
            FL_RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_nx_s = FL_RD_WAIT;
                end else begin
                    state_nx_s = FL_RD_REQ;
                end
            end
            FL_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    state_nx_s = FL_TERM;
                end else begin
                    state_nx_s = FL_RD_WAIT;
                end
            end
            FL_WR_REQ: begin
                if (!avm_waitrequest) begin
                    state_nx_s = FL_TERM;
                end else begin
                    state_nx_s = FL_WR_REQ;
                end
            end
            FL_TERM: begin
                if (FLASH_DATA_RD_ && !FLASH_DATA_WR) begin
                    state_nx_s = FL_IDLE;
                end else begin
                    state_nx_s = FL_TERM;
                end
            end
            default: state_nx_s = FL_IDLE;
        endcase
    end

    // Address/write data are latched as the request starts; read data on valid
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            addr_r  <= {FLASH_AW{1'b0}};
            wdata_r <= 32'h0000_0000;
            dout_r  <= 32'h0000_0000;
        end else begin
            if (state_r == FL_IDLE && !FLASH_DATA_RD_) begin
                addr_r <= flash_addr;
            end else if (state_r == FL_IDLE && FLASH_DATA_WR) begin
                addr_r  <= flash_addr;
                wdata_r <= MID;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
            end
            if (state_r == FL_RD_WAIT && avm_readdatavalid) begin
                dout_r <= avm_rdata;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign avm_addr       = addr_r;
    assign avm_wdata      = wdata_r;
    assign avm_read       = (state_r == FL_RD_REQ);
    assign avm_write      = (state_r == FL_WR_REQ);
    assign FLASH_TERM     = (state_r == FL_TERM);
    assign FLASH_DATA_OUT = dout_r;

endmodule

// File: rtl/sdmac_reg_ctrl.sv
// SDMAC register front end: address decode, control/flash-address registers
// and (with FLASH_EN defined) the Avalon flash-access engine.
module sdmac_reg_ctrl
    import sdmac_reg_pkg::*;
#(
    parameter int         FLASH_AW = 19,
    parameter logic [8:0] CNTR_RST = 9'h000
) (
    input  logic                CLK,
    input  logic                RST_,
    input  logic [7:0]          ADDR,
    input  logic                DMAC_,
    input  logic                AS_,
    input  logic                RW,
    input  logic [31:0]         MID,
    output logic                WDREGREQ,
    output logic                h_0C,
    output logic                h_28,
    output logic                WTC_RD_,
    output logic                CONTR_RD_,
    output logic                ISTR_RD_,
    output logic                SSPBDAT_RD_,
    output logic                VERSION_RD_,
    output logic                DEV_RD_,
    output logic                DSP_RD_,
    output logic                FLASH_ADDR_RD_,
    output logic                FLASH_DATA_RD_,
    output logic                CONTR_WR,
    output logic                ACR_WR,
    output logic                SSPBDAT_WR,
    output logic                VERSION_WR,
    output logic                FLASH_ADDR_WR,
    output logic                FLASH_DATA_WR,
    output logic                ST_DMA,
    output logic                SP_DMA,
    output logic                CLR_INT,
    output logic                FLUSH_,
    output logic [8:0]          CNTR_O,
    output logic                INTENA,
    output logic                PRESET,
    output logic                DMADIR,
    output logic                DMAENA,
    output logic [23:0]         FLASH_ADDR,
    output logic [31:0]         FLASH_DATA_OUT,
    output logic                FLASH_TERM,
    output logic [FLASH_AW-1:0] avm_addr,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_wdata,
    input  logic [31:0]         avm_rdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid
);

    logic       sel_s;
    logic [5:0] lw_s;
    logic [8:0] cntr_r;
    logic       dmaena_r;
    logic [23:0] flash_addr_r;

    assign sel_s = ~DMAC_ & ~AS_;
    assign lw_s  = ADDR[7:2];

    // Longword address decode into read selects, write and action strobes
    always_comb begin
        WDREGREQ       = 1'b0;
        h_0C           = 1'b0;
        h_28           = 1'b0;
        WTC_RD_        = 1'b1;
        CONTR_RD_      = 1'b1;
        ISTR_RD_       = 1'b1;
        SSPBDAT_RD_    = 1'b1;
        VERSION_RD_    = 1'b1;
        DEV_RD_        = 1'b1;
        DSP_RD_        = 1'b1;
        FLASH_ADDR_RD_ = 1'b1;
        FLASH_DATA_RD_ = 1'b1;
        CONTR_WR       = 1'b0;
        ACR_WR         = 1'b0;
        SSPBDAT_WR     = 1'b0;
        VERSION_WR     = 1'b0;
        FLASH_ADDR_WR  = 1'b0;
        FLASH_DATA_WR  = 1'b0;
        ST_DMA         = 1'b0;
        SP_DMA         = 1'b0;
        CLR_INT        = 1'b0;
        FLUSH_         = 1'b1;
        if (sel_s) begin
            case (lw_s)
                OFS_WTC[7:2]:     WTC_RD_ = ~RW;
                OFS_CNTR[7:2]: begin
                    CONTR_RD_ = ~RW;
                    CONTR_WR  = ~RW;
                end
                OFS_ACR[7:2]: begin
                    ACR_WR = ~RW;
                    h_0C   = 1'b1;
                end
                OFS_ST_DMA[7:2]:  ST_DMA   = 1'b1;
                OFS_FLUSH[7:2]:   FLUSH_   = 1'b0;
                OFS_CLR_INT[7:2]: CLR_INT  = 1'b1;
                OFS_ISTR[7:2]:    ISTR_RD_ = ~RW;
                OFS_H28[7:2]:     h_28     = 1'b1;
                OFS_SP_DMA[7:2]:  SP_DMA   = 1'b1;
                OFS_SSPBDAT[7:2]: begin
                    SSPBDAT_RD_ = ~RW;
                    SSPBDAT_WR  = ~RW;
                end
                OFS_VERSION[7:2]: begin
                    VERSION_RD_ = ~RW;
                    VERSION_WR  = ~RW;
                end
                OFS_DEV[7:2]:     DEV_RD_ = ~RW;
                OFS_DSP[7:2]:     DSP_RD_ = ~RW;
                OFS_FLASH_ADDR[7:2]: begin
                    FLASH_ADDR_RD_ = ~RW;
                    FLASH_ADDR_WR  = ~RW;
                end
                OFS_FLASH_DATA[7:2]: begin
                    FLASH_DATA_RD_ = ~RW;
                    FLASH_DATA_WR  = ~RW;
                end
                default:          WDREGREQ = (ADDR[7:4] == OFS_WD_BASE[7:4]);
            endcase
        end else begin
            WDREGREQ = 1'b0;
        end
    end

    // Control, DMA-enable and flash-address registers; stop beats start
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            cntr_r       <= CNTR_RST;
            dmaena_r     <= 1'b0;
            flash_addr_r <= 24'h00_0000;
        end else begin
            if (CONTR_WR) begin
                cntr_r <= MID[8:0];
            end else begin
                cntr_r <= cntr_r;
            end
            if (SP_DMA) begin
                dmaena_r <= 1'b0;
            end else if (ST_DMA) begin
                dmaena_r <= 1'b1;
            end else begin
                dmaena_r <= dmaena_r;
            end
            if (FLASH_ADDR_WR) begin
                flash_addr_r <= MID[23:0];
            end else begin
                flash_addr_r <= flash_addr_r;
            end
        end
    end

    assign CNTR_O     = cntr_r;
    assign INTENA     = cntr_r[CNTR_INTEN];
    assign PRESET     = cntr_r[CNTR_PRESET];
    assign DMADIR     = ~cntr_r[CNTR_DDIR];
    assign DMAENA     = dmaena_r;
    assign FLASH_ADDR = flash_addr_r;

`ifdef FLASH_EN
    sdmac_flash_if #(
        .FLASH_AW(FLASH_AW)
    ) u_flash (
        .CLK              (CLK),
        .RST_             (RST_),
        .FLASH_DATA_RD_   (FLASH_DATA_RD_),
        .FLASH_DATA_WR    (FLASH_DATA_WR),
        .flash_addr       (flash_addr_r[FLASH_AW-1:0]),
        .MID              (MID),
        .avm_addr         (avm_addr),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_wdata        (avm_wdata),
        .avm_rdata        (avm_rdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .FLASH_DATA_OUT   (FLASH_DATA_OUT),
        .FLASH_TERM       (FLASH_TERM)
    );
`else
    logic unused_flash_s;

    assign avm_addr       = {FLASH_AW{1'b0}};
    assign avm_read       = 1'b0;
    assign avm_write      = 1'b0;
    assign avm_wdata      = 32'h0000_0000;
    assign FLASH_DATA_OUT = 32'h0000_0000;
    assign FLASH_TERM     = 1'b0;
    assign unused_flash_s = ^{avm_rdata, avm_waitrequest, avm_readdatavalid, MID[31:24]};
`endif

endmodule

// File: tb/tb_sdmac_reg_ctrl.sv
// Directed bench for sdmac_reg_ctrl; flash-engine steps run when FLASH_EN is defined.
module tb_sdmac_reg_ctrl;

    logic        CLK = 1'b0;
    logic        RST_;
    logic [7:0]  ADDR;
    logic        DMAC_, AS_, RW;
    logic [31:0] MID;
    logic        WDREGREQ, h_0C, h_28;
    logic        WTC_RD_, CONTR_RD_, ISTR_RD_, SSPBDAT_RD_, VERSION_RD_, DEV_RD_, DSP_RD_;
    logic        FLASH_ADDR_RD_, FLASH_DATA_RD_;
    logic        CONTR_WR, ACR_WR, SSPBDAT_WR, VERSION_WR, FLASH_ADDR_WR, FLASH_DATA_WR;
    logic        ST_DMA, SP_DMA, CLR_INT, FLUSH_;
    logic [8:0]  CNTR_O;
    logic        INTENA, PRESET, DMADIR, DMAENA;
    logic [23:0] FLASH_ADDR;
    logic [31:0] FLASH_DATA_OUT;
    logic        FLASH_TERM;
    logic [18:0] avm_addr;
    logic        avm_read, avm_write;
    logic [31:0] avm_wdata, avm_rdata;
    logic        avm_waitrequest, avm_readdatavalid;

    int vec  = 0;
    int miss = 0;

    // Active-high view of every strobe, bit order fixed by the bench
    logic [21:0] stb;
    assign stb = {WDREGREQ, h_28, h_0C, ~FLUSH_, CLR_INT, SP_DMA, ST_DMA,
                  FLASH_DATA_WR, FLASH_ADDR_WR, VERSION_WR, SSPBDAT_WR, ACR_WR, CONTR_WR,
                  ~FLASH_DATA_RD_, ~FLASH_ADDR_RD_, ~DSP_RD_, ~DEV_RD_, ~VERSION_RD_,
                  ~SSPBDAT_RD_, ~ISTR_RD_, ~CONTR_RD_, ~WTC_RD_};

    sdmac_reg_ctrl dut (
        .CLK(CLK), .RST_(RST_), .ADDR(ADDR), .DMAC_(DMAC_), .AS_(AS_), .RW(RW), .MID(MID),
        .WDREGREQ(WDREGREQ), .h_0C(h_0C), .h_28(h_28),
        .WTC_RD_(WTC_RD_), .CONTR_RD_(CONTR_RD_), .ISTR_RD_(ISTR_RD_),
        .SSPBDAT_RD_(SSPBDAT_RD_), .VERSION_RD_(VERSION_RD_), .DEV_RD_(DEV_RD_),
        .DSP_RD_(DSP_RD_), .FLASH_ADDR_RD_(FLASH_ADDR_RD_), .FLASH_DATA_RD_(FLASH_DATA_RD_),
        .CONTR_WR(CONTR_WR), .ACR_WR(ACR_WR), .SSPBDAT_WR(SSPBDAT_WR),
        .VERSION_WR(VERSION_WR), .FLASH_ADDR_WR(FLASH_ADDR_WR), .FLASH_DATA_WR(FLASH_DATA_WR),
        .ST_DMA(ST_DMA), .SP_DMA(SP_DMA), .CLR_INT(CLR_INT), .FLUSH_(FLUSH_),
        .CNTR_O(CNTR_O), .INTENA(INTENA), .PRESET(PRESET), .DMADIR(DMADIR), .DMAENA(DMAENA),
        .FLASH_ADDR(FLASH_ADDR), .FLASH_DATA_OUT(FLASH_DATA_OUT), .FLASH_TERM(FLASH_TERM),
        .avm_addr(avm_addr), .avm_read(avm_read), .avm_write(avm_write),
        .avm_wdata(avm_wdata), .avm_rdata(avm_rdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic acc(input logic [7:0] a, input logic rw, input logic [31:0] d);
        ADDR = a; RW = rw; MID = d; DMAC_ = 1'b0; AS_ = 1'b0;
        #1;
    endtask

    task automatic idle;
        DMAC_ = 1'b1; AS_ = 1'b1; RW = 1'b1; ADDR = 8'h00; MID = 32'h0;
        #1;
    endtask

    // Hand-written register map: which strobes a selected access must raise
    function automatic logic [21:0] exp_stb(input logic [7:0] a, input logic rw);
        logic [21:0] e;
        e = 22'd0;
        case (a[7:2])
            6'h01: e[0] = rw;
            6'h02: begin e[1] = rw;  e[9]  = ~rw; end
            6'h03: begin e[10] = ~rw; e[19] = 1'b1; end
            6'h04: e[15] = 1'b1;
            6'h05: e[18] = 1'b1;
            6'h06: e[17] = 1'b1;
            6'h07: e[2] = rw;
            6'h0A: e[20] = 1'b1;
            6'h0F: e[16] = 1'b1;
            6'h10, 6'h11, 6'h12, 6'h13: e[21] = 1'b1;
            6'h16: begin e[3] = rw; e[11] = ~rw; end
            6'h18: begin e[4] = rw; e[12] = ~rw; end
            6'h19: e[5] = rw;
            6'h1A: e[6] = rw;
            6'h1B: begin e[7] = rw; e[13] = ~rw; end
            6'h1C: begin e[8] = rw; e[14] = ~rw; end
            default: e = 22'd0;
        endcase
        return e;
    endfunction

    initial begin
        RST_ = 1'b1; avm_rdata = 32'h0; avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0;
        DMAC_ = 1'b1; AS_ = 1'b1; RW = 1'b1; ADDR = 8'h00; MID = 32'h0;
        #3 RST_ = 1'b0;
        #3;
        chk("rst_cntr",   {23'd0, CNTR_O}, 32'h000);
        chk("rst_dmaena", {31'd0, DMAENA}, 32'd0);
        chk("rst_dmadir", {31'd0, DMADIR}, 32'd1);
        chk("rst_intena", {31'd0, INTENA}, 32'd0);
        chk("rst_preset", {31'd0, PRESET}, 32'd0);
        chk("rst_term",   {31'd0, FLASH_TERM}, 32'd0);
        chk("rst_dout",   FLASH_DATA_OUT, 32'h0);
        chk("rst_avm",    {30'd0, avm_read, avm_write}, 32'd0);
        chk("rst_faddr",  {8'd0, FLASH_ADDR}, 32'h0);
        chk("rst_stb",    {10'd0, stb}, 32'd0);
        tick; tick;
        RST_ = 1'b1;
        tick;

        acc(8'h08, 1'b0, 32'h0000_0016);
        chk("cntr_wr_stb", {10'd0, stb}, {10'd0, exp_stb(8'h08, 1'b0)});
        tick; idle;
        chk("cntr_val",    {23'd0, CNTR_O}, 32'h016);
        chk("cntr_intena", {31'd0, INTENA}, 32'd1);
        chk("cntr_preset", {31'd0, PRESET}, 32'd1);
        chk("cntr_dmadir", {31'd0, DMADIR}, 32'd0);
        acc(8'h08, 1'b1, 32'h0);
        chk("cntr_rd_stb", {10'd0, stb}, 32'h0000_0002);
        acc(8'h0B, 1'b1, 32'h0);
        chk("cntr_rd_lowbits", {10'd0, stb}, 32'h0000_0002);
        acc(8'h08, 1'b0, 32'h0000_01FF);
        tick; idle;
        chk("cntr_1ff",    {23'd0, CNTR_O}, 32'h1FF);
        chk("cntr_no_dma", {31'd0, DMAENA}, 32'd0);

        acc(8'h10, 1'b1, 32'h0);
        tick; idle;
        chk("st_dma", {31'd0, DMAENA}, 32'd1);
        acc(8'h3C, 1'b0, 32'h0);
        tick; idle;
        chk("sp_dma", {31'd0, DMAENA}, 32'd0);

        acc(8'h43, 1'b1, 32'h0);
        chk("wd_43", {10'd0, stb}, 32'h0020_0000);
        acc(8'h0C, 1'b0, 32'h0);
        chk("acr_wr", {10'd0, stb}, 32'h0008_0400);
        ADDR = 8'h08; RW = 1'b1; DMAC_ = 1'b0; AS_ = 1'b1; #1;
        chk("no_as", {10'd0, stb}, 32'd0);
        idle;

        acc(8'h6C, 1'b0, 32'h0000_0123);
        tick; idle;
        chk("faddr", {8'd0, FLASH_ADDR}, 32'h0000_0123);

`ifdef FLASH_EN
        acc(8'h70, 1'b1, 32'h0);
        tick;
        chk("rd_req",  {31'd0, avm_read}, 32'd1);
        chk("rd_addr", {13'd0, avm_addr}, 32'h0000_0123);
        tick; tick;
        chk("rd_hold", {31'd0, avm_read}, 32'd1);
        avm_waitrequest = 1'b0;
        tick;
        avm_waitrequest = 1'b1;
        chk("rd_accepted", {31'd0, avm_read}, 32'd0);
        tick; tick;
        avm_readdatavalid = 1'b1; avm_rdata = 32'hDEAD_BEEF;
        tick;
        avm_readdatavalid = 1'b0; avm_rdata = 32'h0;
        chk("rd_data", FLASH_DATA_OUT, 32'hDEAD_BEEF);
        chk("rd_term", {31'd0, FLASH_TERM}, 32'd1);
        tick; tick;
        chk("rd_term_hold", {31'd0, FLASH_TERM}, 32'd1);
        idle;
        tick;
        chk("rd_term_rel", {31'd0, FLASH_TERM}, 32'd0);

        acc(8'h70, 1'b0, 32'hCAFE_F00D);
        tick;
        chk("wr_req",   {31'd0, avm_write}, 32'd1);
        chk("wr_wdata", avm_wdata, 32'hCAFE_F00D);
        tick;
        chk("wr_hold",  {31'd0, avm_write}, 32'd1);
        avm_waitrequest = 1'b0;
        tick;
        avm_waitrequest = 1'b1;
        chk("wr_term",  {31'd0, FLASH_TERM}, 32'd1);
        chk("wr_done",  {31'd0, avm_write}, 32'd0);
        idle;
        tick;
        chk("wr_term_rel", {31'd0, FLASH_TERM}, 32'd0);

        acc(8'h70, 1'b1, 32'h0);
        avm_waitrequest = 1'b0;
        tick; tick;
        avm_waitrequest = 1'b1;
        chk("rw_in_wait", {31'd0, FLASH_TERM}, 32'd0);
        RST_ = 1'b0;
        #1;
        chk("rst_mid_term", {31'd0, FLASH_TERM}, 32'd0);
        chk("rst_mid_dout", FLASH_DATA_OUT, 32'h0);
        RST_ = 1'b1;
        idle;
        avm_readdatavalid = 1'b1; avm_rdata = 32'h1234_5678;
        tick;
        avm_readdatavalid = 1'b0;
        chk("rst_mid_idle_dout", FLASH_DATA_OUT, 32'h0);
        chk("rst_mid_idle_term", {31'd0, FLASH_TERM}, 32'd0);
`else
        acc(8'h70, 1'b1, 32'h0);
        avm_waitrequest = 1'b0;
        tick;
        avm_readdatavalid = 1'b1; avm_rdata = 32'hDEAD_BEEF;
        tick;
        avm_readdatavalid = 1'b0;
        chk("nofl_read", {31'd0, avm_read}, 32'd0);
        chk("nofl_term", {31'd0, FLASH_TERM}, 32'd0);
        chk("nofl_dout", FLASH_DATA_OUT, 32'h0);
        acc(8'h70, 1'b0, 32'hCAFE_F00D);
        tick;
        chk("nofl_write", {31'd0, avm_write}, 32'd0);
        chk("nofl_wdata", avm_wdata, 32'h0);
        avm_waitrequest = 1'b1;
        idle;
`endif

        for (int i = 0; i < 64; i++) begin
            for (int r = 0; r < 2; r++) begin
                ADDR = 8'(i * 4); RW = r[0]; MID = 32'h0;
                DMAC_ = 1'b1; AS_ = 1'b0; #1;
                chk($sformatf("sweep_off_%02h_%0d", ADDR, r), {10'd0, stb}, 32'd0);
                DMAC_ = 1'b0; #1;
                chk($sformatf("sweep_on_%02h_%0d", ADDR, r), {10'd0, stb},
                    {10'd0, exp_stb(ADDR, RW)});
            end
        end
        idle;

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
